qed_result_checker: RTL
=======================

Name: qed_result_checker

Overview:
- Commit-side counterpart of the QED instruction transformer.
- The transformer turns each original instruction (registers x1–x15, lower memory) into a duplicate that uses x17–x31 and the upper memory region.
- This block watches the core's two register-writeback commit ports and queues original results in program order. It pairs each duplicate result with its original, compares them, and flags any mismatch.
- It raises qed_ready when every original has a checked duplicate. The formal property is "qed_ready implies !qed_error".

Parameters:
DEPTH, 16, number of original results that can be outstanding; power of 2, at least 4
DATA_W, 32, width of committed result data
CNT_W, 16, width of the original/duplicate commit counters (saturating)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
c0_valid  input  1  commit port 0 retires a register write (port 0 is older)
c0_rd  input  5  destination register, port 0
c0_data  input  DATA_W  written value, port 0
c1_valid  input  1  commit port 1 retires a register write (younger)
c1_rd  input  5  destination register, port 1
c1_data  input  DATA_W  written value, port 1
qed_check_valid  output  1  one or more compares completed this cycle
qed_error  output  1  sticky error flag
qed_error_code  output  3  code of the first error, held
qed_ready  output  1  counts equal, queue empty, orig_count nonzero
orig_count  output  CNT_W  originals committed so far (saturates)
dup_count  output  CNT_W  duplicates committed so far (saturates)

Behaviour:
- Reset asynchronously clears the queue, both counters and all outputs to 0. Reset mid-run discards any pending entries.

Commit classification:
- rd == 0: ignored (no architectural effect).
- rd[4] == 0: original. Push the pair {rd[3:0], data}.
- rd[4] == 1: duplicate. Pop the oldest entry and compare it.

Per-cycle processing:
- Port 0 is processed before port 1.
- A duplicate on port 1 may pair with an original pushed by port 0 in the same cycle (bypass). The queue contents must match what strictly sequential processing would produce.
- Up to 2 pushes or 2 pops per cycle, or 1 push plus 1 pop.

Compare rules, per duplicate:
- Index mismatch: dup rd[3:0] differs from the entry's index. Code 3'b010.
- Data mismatch: indices match but data differs. Code 3'b001.
- Underflow: duplicate arrives with no pending original (including the bypass case). Code 3'b011. Nothing is popped.
- Overflow: a push would exceed DEPTH. Code 3'b100. The push is dropped.

Error reporting:
- Errors take effect in the cycle after the commit (registered outputs).
- qed_error_code records only the first error. If two errors occur in one cycle, port 0's error wins.
- qed_error and qed_error_code stay set until reset. Checking continues after an error.

Output timing:
- qed_check_valid is a 1-cycle pulse, registered, asserted the cycle after any compare.
- qed_ready is registered and computed from next-state values. It drops as soon as a new original commits.
- Both counters increment by 0, 1 or 2 per cycle and saturate at all-ones. After saturation, qed_ready is based on queue empty only.

Decomposition:
- Shared package qed_pkg:
  - error-code localparams QED_ERR_NONE / DATA / RD / UNDERFLOW / OVERFLOW
  - the QED register-half split constant (bit 4)
  - typedef qed_entry_t {logic [3:0] idx; logic [DATA_W-1:0] data}
- One natural sub-module: qed_dual_port_fifo.
  - Circular buffer with 0–2 pushes and 0–2 pops per cycle.
  - Occupancy counter of width $clog2(DEPTH)+1.
  - Peeks at head and head+1.
- The top level holds classification, bypass, compare, counters and sticky error logic.

Test Plan:
- c0 commits x5=0xDEAD_BEEF; later c1 commits x21=0xDEAD_BEEF -> qed_check_valid pulses once, qed_error=0; qed_ready=1 with orig=1, dup=1.
- Same cycle: c0 x3=0x10 and c1 x19=0x10 (bypass) -> no underflow, qed_ready=1 next cycle, queue empty.
- Originals x1=1, x2=2 then duplicates x17=1, x18=3 -> qed_error=1, code 3'b001 the cycle after the second compare; a later good pair does not clear the error.
- Duplicate x20=7 with empty queue -> code 3'b011, dup_count=1, qed_ready=0.
- 17 originals with DEPTH=16 -> code 3'b100 on the 17th push; orig_count=17.
- 8 originals, then assert rst_n=0 mid-stream -> all outputs 0 immediately; after release a fresh pair passes cleanly.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared types and constants for the QED commit-side result checker.
package qed_pkg;

   localparam int QED_DATA_W = 32;
   localparam int QED_HALF_BIT = 4;

   localparam logic [2:0] QED_ERR_NONE = 3'b000;
   localparam logic [2:0] QED_ERR_DATA = 3'b001;
   localparam logic [2:0] QED_ERR_RD = 3'b010;
   localparam logic [2:0] QED_ERR_UNDERFLOW = 3'b011;
   localparam logic [2:0] QED_ERR_OVERFLOW = 3'b100;

   typedef struct packed {
      logic [3:0] idx;
      logic [QED_DATA_W-1:0] data;
   } qed_entry_t;

   function automatic logic [2:0] qed_cmp(
      input qed_entry_t e,
      input logic [3:0] idx,
      input logic [QED_DATA_W-1:0] data
   );
      if (e.idx != idx) return QED_ERR_RD;
      if (e.data != data) return QED_ERR_DATA;
      return QED_ERR_NONE;
   endfunction

endpackage

// File: rtl/qed_dual_port_fifo.sv
// Circular buffer accepting 0-2 pushes and 0-2 pops per cycle.
module qed_dual_port_fifo
   import qed_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] wr_n,
   input  qed_entry_t wr_d0,
   input  qed_entry_t wr_d1,
   input  logic [1:0] rd_n,
   output qed_entry_t head0,
   output qed_entry_t head1,
   output logic [AW:0] count
);

   qed_entry_t mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head_nx;
   logic [AW-1:0] tail_nx;

   assign head_nx = head + AW'(1);
   assign tail_nx = tail + AW'(1);
   assign head0 = mem[head];
   assign head1 = mem[head_nx];

   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) mem[tail] <= wr_d0;
      if (wr_n == 2'd2) mem[tail_nx] <= wr_d1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         head <= head + AW'(rd_n);
         tail <= tail + AW'(wr_n);
         count <= count + (AW+1)'(wr_n) - (AW+1)'(rd_n);
      end
   end

endmodule

// File: rtl/qed_result_checker.sv
// Pairs duplicate commit results with queued originals and flags mismatches.
module qed_result_checker
   import qed_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DATA_W = QED_DATA_W,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c0_valid,
   input  logic [4:0]        c0_rd,
   input  logic [DATA_W-1:0] c0_data,
   input  logic              c1_valid,
   input  logic [4:0]        c1_rd,
   input  logic [DATA_W-1:0] c1_data,
   output logic              qed_check_valid,
   output logic              qed_error,
   output logic [2:0]        qed_error_code,
   output logic              qed_ready,
   output logic [CNT_W-1:0]  orig_count,
   output logic [CNT_W-1:0]  dup_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   qed_entry_t e0, e1, h0, h1, ref1;
   qed_entry_t wr_d0, wr_d1;
   logic [AW:0] cnt, cnt1, cnt_n;
   logic [1:0] wr_n, rd_n, n_orig, n_dup;
   logic orig0, dup0, orig1, dup1;
   logic push0, pop0, push1, pop1, bypass;
   logic cmp0, cmp1;
   logic [2:0] err0, err1, first_err;
   logic [CNT_W-1:0] orig_n, dup_n;
   logic ready_n;

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [1:0] n
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(n);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   qed_dual_port_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_n  (wr_n),
      .wr_d0 (wr_d0),
      .wr_d1 (wr_d1),
      .rd_n  (rd_n),
      .head0 (h0),
      .head1 (h1),
      .count (cnt)
   );

   always_comb begin
      e0 = '{idx: c0_rd[3:0], data: c0_data};
      e1 = '{idx: c1_rd[3:0], data: c1_data};
      orig0 = c0_valid && c0_rd != 5'd0 && !c0_rd[QED_HALF_BIT];
      dup0 = c0_valid && c0_rd[QED_HALF_BIT];
      orig1 = c1_valid && c1_rd != 5'd0 && !c1_rd[QED_HALF_BIT];
      dup1 = c1_valid && c1_rd[QED_HALF_BIT];
      push0 = 1'b0;
      pop0 = 1'b0;
      push1 = 1'b0;
      pop1 = 1'b0;
      bypass = 1'b0;
      cmp0 = 1'b0;
      cmp1 = 1'b0;
      err0 = QED_ERR_NONE;
      err1 = QED_ERR_NONE;
      ref1 = h0;
      if (orig0) begin
         if (cnt == FULL) err0 = QED_ERR_OVERFLOW;
         else push0 = 1'b1;
      end
      if (dup0) begin
         if (cnt == '0) err0 = QED_ERR_UNDERFLOW;
         else begin
            pop0 = 1'b1;
            cmp0 = 1'b1;
            err0 = qed_cmp(h0, c0_rd[3:0], c0_data);
         end
      end
      cnt1 = cnt + (AW+1)'(push0) - (AW+1)'(pop0);
      if (orig1) begin
         if (cnt1 == FULL) err1 = QED_ERR_OVERFLOW;
         else push1 = 1'b1;
      end
      if (dup1) begin
         if (cnt1 == '0) err1 = QED_ERR_UNDERFLOW;
         else begin
            cmp1 = 1'b1;
            // Oldest entry after port 0: next head, port-0 push, or head.
            if (pop0) ref1 = h1;
            else if (push0 && cnt == '0) begin
               ref1 = e0;
               bypass = 1'b1;
            end
            pop1 = !bypass;
            err1 = qed_cmp(ref1, c1_rd[3:0], c1_data);
         end
      end
      wr_n = 2'(push0 && !bypass) + 2'(push1);
      wr_d0 = (push0 && !bypass) ? e0 : e1;
      wr_d1 = e1;
      rd_n = 2'(pop0) + 2'(pop1);
      cnt_n = cnt + (AW+1)'(wr_n) - (AW+1)'(rd_n);
      first_err = (err0 != QED_ERR_NONE) ? err0 : err1;
      n_orig = 2'(orig0) + 2'(orig1);
      n_dup = 2'(dup0) + 2'(dup1);
      orig_n = sat_add(orig_count, n_orig);
      dup_n = sat_add(dup_count, n_dup);
      ready_n = cnt_n == '0 && orig_n != '0 &&
                (orig_n == dup_n || &orig_n || &dup_n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qed_check_valid <= 1'b0;
         qed_error <= 1'b0;
         qed_error_code <= QED_ERR_NONE;
         qed_ready <= 1'b0;
         orig_count <= '0;
         dup_count <= '0;
      end else begin
         qed_check_valid <= cmp0 || cmp1;
         if (!qed_error && first_err != QED_ERR_NONE) begin
            qed_error <= 1'b1;
            qed_error_code <= first_err;
         end
         qed_ready <= ready_n;
         orig_count <= orig_n;
         dup_count <= dup_n;
      end
   end

endmodule
